calc_ctrl: RTL

//   Sequencing controller for the keypad calculator. It consumes the decoded key

---
 rtl/calc_ctrl_if.sv | 26 ++
 rtl/calc_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/calc_ctrl_if.sv
// Keypad-to-calculator bundle: decoded key strobe in, display value/sign/result pulse out.
// master = keypad side (drives keys), slave = calc_ctrl.
interface calc_ctrl_if #(
    parameter int OP_W = 10
);
    logic            key_valid;
    logic            is_number;
    logic            is_op;
    logic            is_eq;
    logic [3:0]      num_val;
    logic [1:0]      op_val;
    logic [OP_W:0]   disp_val;
    logic            disp_neg;
    logic            res_valid;
    logic [1:0]      state_o;

    modport master (
        output key_valid, is_number, is_op, is_eq, num_val, op_val,
        input  disp_val, disp_neg, res_valid, state_o
    );

    modport slave (
        input  key_valid, is_number, is_op, is_eq, num_val, op_val,
        output disp_val, disp_neg, res_valid, state_o
    );
endinterface

// File: rtl/calc_ctrl.sv
// Keypad calculator sequencer: builds A, op, B from key strobes and shows A+B / A-B on '='.
// Latency: display updates 1 clk after the key; no backpressure. Optional CALC_CHAIN_EN: op in S_B chains.
module calc_ctrl #(
    parameter int NDIG = 3,
    parameter int OP_W = 10
) (
    input  logic         clk,
    input  logic         reset,
    calc_ctrl_if.slave   bus
);
    localparam int DC_W = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_OP  = 2'b01,
        S_B   = 2'b10,
        S_RES = 2'b11
    } state_t;

    localparam logic [1:0] OP_PLUS  = 2'd1;
    localparam logic [1:0] OP_MINUS = 2'd2;

    state_t            state_q, state_d;
    logic [OP_W:0]     a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [DC_W-1:0]   dcnt_q, dcnt_d;
    logic [OP_W:0]     res_q, res_d;
    logic              res_neg_q, res_neg_d;
    logic [OP_W:0]     disp_val_q, disp_val_d;
    logic              disp_neg_q, disp_neg_d;
    logic              res_valid_q, pulse_d;

    logic              key_num, key_op, key_eq;
    logic              digit_room;
    logic [OP_W+1:0]   eval;
    logic [OP_W:0]     eval_mag;
    logic              eval_neg;

    // Class priority number > op > eq; an operator key with a reserved code counts as nothing.
    assign key_num    = bus.key_valid & bus.is_number;
    assign key_op     = bus.key_valid & ~bus.is_number & bus.is_op &
                        ((bus.op_val == OP_PLUS) | (bus.op_val == OP_MINUS));
    assign key_eq     = bus.key_valid & ~bus.is_number & ~bus.is_op & bus.is_eq;
    assign digit_room = (dcnt_q < DC_W'(NDIG));

    // x*10 + d, with x*10 formed as shift-and-add; the digit limit keeps it within OP_W bits.
    function automatic logic [OP_W-1:0] append_digit(input logic [OP_W-1:0] x,
                                                     input logic [3:0]      d);
        logic [OP_W+3:0] w;
        w = ({4'b0, x} << 3) + ({4'b0, x} << 1);
        return w[OP_W-1:0] + {{(OP_W-4){1'b0}}, d};
    endfunction

    // Returns {neg, magnitude}; subtraction is done as sign + magnitude.
    function automatic logic [OP_W+1:0] evaluate(input logic [OP_W:0]   x,
                                                 input logic [OP_W-1:0] y,
                                                 input logic [1:0]      op);
        logic [OP_W:0] ye;
        ye = {1'b0, y};
        if (op == OP_MINUS) begin
            if (x >= ye) return {1'b0, x - ye};
            else         return {1'b1, ye - x};
        end
        return {1'b0, x + ye};
    endfunction

    assign eval     = evaluate(a_q, b_q, op_q);
    assign eval_mag = eval[OP_W:0];
    assign eval_neg = eval[OP_W+1];

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        dcnt_d     = dcnt_q;
        res_d      = res_q;
        res_neg_d  = res_neg_q;
        pulse_d    = 1'b0;
        disp_val_d = disp_val_q;
        disp_neg_d = disp_neg_q;

        case (state_q)
            S_A: begin
                if (key_num) begin
                    if (digit_room) begin
                        a_d    = {1'b0, append_digit(a_q[OP_W-1:0], bus.num_val)};
                        dcnt_d = dcnt_q + DC_W'(1);
                    end
                end else if (key_op) begin
                    op_d    = bus.op_val;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (key_num) begin
                    b_d     = {{(OP_W-4){1'b0}}, bus.num_val};
                    dcnt_d  = DC_W'(1);
                    state_d = S_B;
                end else if (key_op) begin
                    op_d = bus.op_val;
                end
            end
            S_B: begin
                if (key_num) begin
                    if (digit_room) begin
                        b_d    = append_digit(b_q, bus.num_val);
                        dcnt_d = dcnt_q + DC_W'(1);
                    end
                end else if (key_eq) begin
                    res_d     = eval_mag;
                    res_neg_d = eval_neg;
                    pulse_d   = 1'b1;
                    state_d   = S_RES;
                end
`ifdef CALC_CHAIN_EN
                else if (key_op && !eval_neg) begin
                    a_d     = eval_mag;
                    op_d    = bus.op_val;
                    pulse_d = 1'b1;
                    state_d = S_OP;
                end
`endif
            end
            default: begin // S_RES
                if (key_num) begin
                    a_d     = {{(OP_W-3){1'b0}}, bus.num_val};
                    b_d     = '0;
                    dcnt_d  = DC_W'(1);
                    state_d = S_A;
                end else if (key_op && !res_neg_q) begin
                    // A holds the full OP_W+1 bit result so chained sums are not clipped.
                    a_d     = res_q;
                    op_d    = bus.op_val;
                    state_d = S_OP;
                end
            end
        endcase

        case (state_d)
            S_A, S_OP: begin
                disp_val_d = a_d;
                disp_neg_d = 1'b0;
            end
            S_B: begin
                disp_val_d = {1'b0, b_d};
                disp_neg_d = 1'b0;
            end
            default: begin
                disp_val_d = res_d;
                disp_neg_d = res_neg_d;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_A;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            dcnt_q      <= '0;
            res_q       <= '0;
            res_neg_q   <= 1'b0;
            disp_val_q  <= '0;
            disp_neg_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            dcnt_q      <= dcnt_d;
            res_q       <= res_d;
            res_neg_q   <= res_neg_d;
            disp_val_q  <= disp_val_d;
            disp_neg_q  <= disp_neg_d;
            res_valid_q <= pulse_d;
        end
    end

    assign bus.disp_val  = disp_val_q;
    assign bus.disp_neg  = disp_neg_q;
    assign bus.res_valid = res_valid_q;
    assign bus.state_o   = state_q;
endmodule
